// File: rtl/down_counter_pkg.sv
// Shared types and defaults for the loadable down counter.
// The state encoding here is the one the counter uses; the prescaler
// option itself is selected with DOWN_COUNTER_PRESCALE_EN.
package down_counter_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int DEFAULT_W        = 4;
    localparam int DEFAULT_PRESCALE = 4;

endpackage

// File: rtl/down_counter_prescaler.sv
// Step-rate divider for the down counter: tick is high on every PRESCALE-th
// enabled cycle. Built only when DOWN_COUNTER_PRESCALE_EN is defined.
module down_counter_prescaler #(
    parameter int PRESCALE = 4
) (
    input  logic clk,
    input  logic res,
    input  logic clr,
    input  logic en,
    output logic tick
);

    localparam int CW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [CW-1:0] LAST = CW'(PRESCALE - 1);

    logic [CW-1:0] cnt_r;

    // Phase counter: clears on reset or load, freezes while en is low.
    always_ff @(posedge clk) begin
        if (res || clr) begin
            cnt_r <= {CW{1'b0}};
        end else if (en) begin
            if (cnt_r == LAST) begin
                cnt_r <= {CW{1'b0}};
            end else begin
                cnt_r <= cnt_r + CW'(1);
            end
        end else begin
            cnt_r <= cnt_r;
        end
    end

    assign tick = en && (cnt_r == LAST);

endmodule

// File: rtl/down_counter.sv
// Loadable down counter with terminal-count pulse and optional auto-reload.
// Define DOWN_COUNTER_PRESCALE_EN to slow the count rate by PRESCALE.
module down_counter
    import down_counter_pkg::*;
#(
    parameter int W        = DEFAULT_W,
    parameter int PRESCALE = DEFAULT_PRESCALE
) (
    input  logic         clk,
    input  logic         res,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         en,
    input  logic         auto_reload,
    output logic [W-1:0] y,
    output logic         busy,
    output logic         done,
    output logic         tc
);

    state_t        state_r;
    logic [W-1:0]  y_r;
    logic [W-1:0]  reload_r;
    logic          busy_r;
    logic          done_r;
    logic          tc_r;
    logic          stop_r;
    logic          tick_s;

`ifdef DOWN_COUNTER_PRESCALE_EN
    down_counter_prescaler #(
        .PRESCALE (PRESCALE)
    ) u_prescaler (
        .clk  (clk),
        .res  (res),
        .clr  (load),
        .en   (en),
        .tick (tick_s)
    );
`else
    // Without the divider every enabled cycle is a step; an illegal
    // PRESCALE setting leaves the counter frozen instead of misbehaving.
    localparam logic PRESCALE_OK = (PRESCALE >= 1);
    assign tick_s = PRESCALE_OK;
`endif

    // Single-process FSM: load wins over counting, reset wins over all.
    // stop_r remembers auto_reload as sampled on the step that reached 0,
    // so a stopping count shows tc with busy still high, then enters DONE.
    always_ff @(posedge clk) begin
        if (res) begin
            state_r  <= IDLE;
            y_r      <= {W{1'b0}};
            reload_r <= {W{1'b0}};
            busy_r   <= 1'b0;
            done_r   <= 1'b0;
            tc_r     <= 1'b0;
            stop_r   <= 1'b0;
        end else if (load) begin
            y_r      <= load_val;
            reload_r <= load_val;
            tc_r     <= 1'b0;
            stop_r   <= 1'b0;
            if (load_val != {W{1'b0}}) begin
                state_r <= RUN;
                busy_r  <= 1'b1;
                done_r  <= 1'b0;
            end else begin
                state_r <= DONE;
                busy_r  <= 1'b0;
                done_r  <= 1'b1;
            end
        end else begin
            tc_r <= 1'b0;
            case (state_r)
                RUN: begin
                    if ((y_r == {W{1'b0}}) && stop_r) begin
                        state_r <= DONE;
                        busy_r  <= 1'b0;
                        done_r  <= 1'b1;
                        stop_r  <= 1'b0;
                    end else if (en && tick_s) begin
                        if (y_r > W'(1)) begin
                            y_r <= y_r - W'(1);
                        end else if (y_r == W'(1)) begin
                            y_r    <= {W{1'b0}};
                            tc_r   <= 1'b1;
                            stop_r <= ~auto_reload;
                        end else begin
                            y_r <= reload_r;
                        end
                    end else begin
                        y_r <= y_r;
                    end
                end
                IDLE, DONE: begin
                    y_r <= y_r;
                end
                default: begin
                    state_r <= IDLE;
                    y_r     <= {W{1'b0}};
                    busy_r  <= 1'b0;
                    done_r  <= 1'b0;
                    stop_r  <= 1'b0;
                end
            endcase
        end
    end

    assign y    = y_r;
    assign busy = busy_r;
    assign done = done_r;
    assign tc   = tc_r;

endmodule

// File: doc/down_counter.md
Name: down_counter

Overview:
Loadable, programmable-width down counter with terminal-count signalling and optional auto-reload.
- Counterpart of the team's free-running up counter: counts from a loaded value toward zero instead of up from zero.
- Used as a countdown timer / event-interval generator next to the up counter in the sessional designs.
- Single clock domain; `clk`/`res` naming matches the existing counter.

Parameters:
- W, 4, counter and load-value width in bits (W >= 2).
- PRESCALE, 4, clock cycles per count step when the prescaler is compiled in (PRESCALE >= 1); ignored otherwise.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- res  in  1  reset, synchronous, active-high.
- load  in  1  load request; sampled each rising edge.
- load_val  in  W  value loaded when load=1.
- en  in  1  count enable; y holds when 0.
- auto_reload  in  1  1 = reload from the stored value after reaching zero; 0 = stop at zero.
- y  out  W  current count (registered).
- busy  out  1  1 while in RUN.
- done  out  1  level; 1 while in DONE.
- tc  out  1  one-cycle terminal-count pulse (registered).

Behaviour:
- Reset: res=1 at an edge forces the following, regardless of other inputs:
  - state=IDLE; y=0, busy=0, done=0, tc=0.
  - Reload register cleared to 0; prescaler cleared.
  - Reset mid-run aborts immediately; no tc is generated.
- States: IDLE, RUN, DONE. Encodings are defined in the package.
- Load, from any state:
  - Priority: load beats en and any count step.
  - Next cycle: y=load_val, and the reload register takes load_val.
  - load_val != 0: go to RUN, busy=1, done=0.
  - load_val == 0: go to DONE, done=1, tc=0.
  - Load mid-run restarts the count; no tc is produced for the abandoned count.
- Count step: occurs in RUN when load=0, en=1 and tick=1.
  - tick is always 1 unless the optional feature is compiled in.
  - y>1: y decrements by 1.
  - y==1: y becomes 0 and tc=1 in the same cycle y first reads 0.
  - y==0 (auto_reload mode only): y becomes the reload register value; tc=0.
- After reaching 0, auto_reload is sampled on the step that takes y to 0:
  - auto_reload=1: stay in RUN. Sequence is N, N-1, ..., 0, N, ... with period N+1 steps and one tc per period.
  - auto_reload=0: go to DONE next cycle; busy=0, done=1, y holds 0.
- en=0: y, state and prescaler hold; tc=0.
- IDLE and DONE: y holds; only load or res cause a change.
- Arithmetic: unsigned, width W. y never wraps below 0, and no borrow is ever generated.
- Maximum load value 2^W-1 counts normally.
- tc is never high in two consecutive cycles unless N=0 auto-reload, which is impossible because load 0 goes to DONE.

Optional Feature:
- Macro: DOWN_COUNTER_PRESCALE_EN.
- Defined: instantiates the prescaler.
  - tick=1 once every PRESCALE cycles in which en=1.
  - The prescaler counter clears on res and on load; it holds when en=0.
  - First step occurs PRESCALE enabled cycles after the load cycle.
- Undefined: tick tied to 1 and PRESCALE unused. Behaviour is identical to PRESCALE=1.

Decomposition:
- Package down_counter_pkg holds:
  - The state typedef (IDLE=2'd0, RUN=2'd1, DONE=2'd2).
  - The default width constant.
- One natural sub-module, down_counter_prescaler (ports: clk, res, clr, en, tick; parameter PRESCALE). It is instantiated only under DOWN_COUNTER_PRESCALE_EN.

Test Plan:
- Basic countdown. res pulse, then load=1 with load_val=5, then en=1 held:
  - y = 5,4,3,2,1,0 on successive cycles.
  - tc high only in the cycle y=0; done=1 and busy=0 from the next cycle.
  - y stays 0.
- Auto-reload. auto_reload=1, load 3, en=1 for 12 cycles:
  - y = 3,2,1,0,3,2,1,0,...
  - tc pulses every 4th cycle, aligned with y=0; busy stays 1.
- Enable gating. Load 6, then en toggles 1,0,0,1:
  - y = 6,5,5,5,4.
  - No tc; busy=1 throughout.
- Load priority and restart:
  - Mid-run at y=6, load_val=2 with en=1 gives y=2 next cycle, then 1,0; tc only at that 0.
  - load_val=0 gives y=0, done=1, tc=0.
- Reset mid-operation and edge values:
  - res asserted at y=3 gives y=0, busy=0, done=0, tc=0 next cycle.
  - load 15 (W=4) counts the full 15..0 with exactly one tc.
- Prescale (macro defined, PRESCALE=4):
  - load 2, en=1: y changes every 4 cycles (2,2,2,2,1,1,1,1,0).
  - Dropping en freezes the prescale phase.
